// File: rtl/teclado_atm_if.sv
// Keypad-side and controller-side signals of the ATM keypad front end.
// The slave modport is the keypad front end; the master modport is the keypad/controller side.
interface teclado_atm_if;
    logic        MODO_MONTO;
    logic [3:0]  COLUMNAS;
    logic [3:0]  FILAS;
    logic [3:0]  DIGITO;
    logic        DIGITO_STB;
    logic [31:0] MONTO;
    logic        MONTO_STB;
    logic        TIPO_TRANS;
    logic        TECLA_INVALIDA;

    modport master (
        output MODO_MONTO, COLUMNAS,
        input  FILAS, DIGITO, DIGITO_STB, MONTO, MONTO_STB, TIPO_TRANS, TECLA_INVALIDA
    );

    modport slave (
        input  MODO_MONTO, COLUMNAS,
        output FILAS, DIGITO, DIGITO_STB, MONTO, MONTO_STB, TIPO_TRANS, TECLA_INVALIDA
    );
endinterface

// File: rtl/teclado_atm.sv
// 4x4 keypad scanner/debouncer feeding PIN digits and decimal amounts to the ATM controller.
// States: SCAN = row dwell and column sample | DEBOUNCE = confirm press | HOLD = wait for release.
module teclado_atm #(
    parameter int SCAN_CYCLES     = 2,
    parameter int DEBOUNCE_CYCLES = 3
) (
    input  logic         CLK,
    input  logic         RESET,
    teclado_atm_if.slave bus
);
    localparam logic [15:0] SCAN_LOAD = 16'(SCAN_CYCLES - 1);
    localparam logic [15:0] DEB_LOAD  = 16'(DEBOUNCE_CYCLES);
    localparam logic [3:0]  K_A    = 4'd10;
    localparam logic [3:0]  K_B    = 4'd11;
    localparam logic [3:0]  K_C    = 4'd12;
    localparam logic [3:0]  K_D    = 4'd13;
    localparam logic [3:0]  K_STAR = 4'd14;
    localparam logic [3:0]  K_HASH = 4'd15;

    typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_HOLD} state_t;

    state_t      state_q, state_d;
    logic [1:0]  row_q, row_d, col_q, col_d;
    logic [3:0]  pat_q, pat_d, filas_q, filas_d;
    logic [15:0] scan_cnt_q, scan_cnt_d, deb_cnt_q, deb_cnt_d;
    logic        key_event;
    logic [3:0]  col_low;
    logic        single_low;
    logic [1:0]  col_idx;
    logic [3:0]  key_code;

    logic        modo_q, mode_chg;
    logic [31:0] acc_q, acc_d, acc_base;
    logic [3:0]  cnt_q, cnt_d, cnt_base;
    logic [3:0]  digito_q, digito_d;
    logic        digito_stb_q, digito_stb_d;
    logic [31:0] monto_q, monto_d;
    logic        monto_stb_q, monto_stb_d;
    logic        tipo_q, tipo_d;
    logic        inval_q, inval_d;

    assign col_low    = ~bus.COLUMNAS;
    assign single_low = (col_low != 4'd0) && ((col_low & (col_low - 4'd1)) == 4'd0);

    always_comb begin
        col_idx = 2'd0;
        case (col_low)
            4'b0010: col_idx = 2'd1;
            4'b0100: col_idx = 2'd2;
            4'b1000: col_idx = 2'd3;
            default: col_idx = 2'd0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        pat_d      = pat_q;
        scan_cnt_d = scan_cnt_q;
        deb_cnt_d  = deb_cnt_q;
        key_event  = 1'b0;
        case (state_q)
            ST_SCAN: begin
                if (scan_cnt_q == 16'd0) begin
                    scan_cnt_d = SCAN_LOAD;
                    if (single_low) begin
                        col_d     = col_idx;
                        pat_d     = bus.COLUMNAS;
                        deb_cnt_d = DEB_LOAD;
                        state_d   = ST_DEBOUNCE;
                    end else begin
                        row_d = row_q + 2'd1;
                    end
                end else begin
                    scan_cnt_d = scan_cnt_q - 16'd1;
                end
            end
            ST_DEBOUNCE: begin
                if (deb_cnt_q == 16'd0) begin
                    key_event = 1'b1;
                    deb_cnt_d = DEB_LOAD;
                    state_d   = ST_HOLD;
                end else if (bus.COLUMNAS == pat_q) begin
                    deb_cnt_d = deb_cnt_q - 16'd1;
                end else begin
                    row_d      = 2'd0;
                    scan_cnt_d = SCAN_LOAD;
                    state_d    = ST_SCAN;
                end
            end
            ST_HOLD: begin
                if (bus.COLUMNAS != 4'hF) begin
                    deb_cnt_d = DEB_LOAD;
                end else if (deb_cnt_q == 16'd1) begin
                    row_d      = 2'd0;
                    scan_cnt_d = SCAN_LOAD;
                    state_d    = ST_SCAN;
                end else begin
                    deb_cnt_d = deb_cnt_q - 16'd1;
                end
            end
            default: state_d = ST_SCAN;
        endcase
        filas_d = ~(4'b0001 << row_d);
    end

    always_comb begin
        key_code = 4'd0;
        case ({row_q, col_q})
            4'd0:  key_code = 4'd1;
            4'd1:  key_code = 4'd2;
            4'd2:  key_code = 4'd3;
            4'd3:  key_code = K_A;
            4'd4:  key_code = 4'd4;
            4'd5:  key_code = 4'd5;
            4'd6:  key_code = 4'd6;
            4'd7:  key_code = K_B;
            4'd8:  key_code = 4'd7;
            4'd9:  key_code = 4'd8;
            4'd10: key_code = 4'd9;
            4'd11: key_code = K_C;
            4'd12: key_code = K_STAR;
            4'd13: key_code = 4'd0;
            4'd14: key_code = K_HASH;
            4'd15: key_code = K_D;
        endcase
    end

    // A mode change wipes the partial amount; an event in the same cycle builds on the cleared value.
    assign mode_chg = bus.MODO_MONTO != modo_q;
    assign acc_base = mode_chg ? 32'd0 : acc_q;
    assign cnt_base = mode_chg ? 4'd0 : cnt_q;

    always_comb begin
        acc_d        = acc_base;
        cnt_d        = cnt_base;
        digito_d     = digito_q;
        digito_stb_d = 1'b0;
        monto_d      = monto_q;
        monto_stb_d  = 1'b0;
        tipo_d       = tipo_q;
        inval_d      = 1'b0;
        if (key_event) begin
            if (key_code == K_A) begin
                tipo_d = 1'b0;
            end else if (key_code == K_B) begin
                tipo_d = 1'b1;
            end else if (!bus.MODO_MONTO) begin
                if (key_code <= 4'd9) begin
                    digito_d     = key_code;
                    digito_stb_d = 1'b1;
                end else begin
                    inval_d = 1'b1;
                end
            end else if (key_code <= 4'd9) begin
                if (cnt_base < 4'd9) begin
                    acc_d = (acc_base << 3) + (acc_base << 1) + {28'd0, key_code};
                    cnt_d = cnt_base + 4'd1;
                end else begin
                    inval_d = 1'b1;
                end
            end else if (key_code == K_STAR) begin
                acc_d = 32'd0;
                cnt_d = 4'd0;
            end else if (key_code == K_HASH && cnt_base != 4'd0) begin
                monto_d     = acc_base;
                monto_stb_d = 1'b1;
                acc_d       = 32'd0;
                cnt_d       = 4'd0;
            end else begin
                inval_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= ST_SCAN;
            row_q        <= 2'd0;
            col_q        <= 2'd0;
            pat_q        <= 4'hF;
            filas_q      <= 4'b1110;
            scan_cnt_q   <= SCAN_LOAD;
            deb_cnt_q    <= 16'd0;
            modo_q       <= 1'b0;
            acc_q        <= 32'd0;
            cnt_q        <= 4'd0;
            digito_q     <= 4'd0;
            digito_stb_q <= 1'b0;
            monto_q      <= 32'd0;
            monto_stb_q  <= 1'b0;
            tipo_q       <= 1'b0;
            inval_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            pat_q        <= pat_d;
            filas_q      <= filas_d;
            scan_cnt_q   <= scan_cnt_d;
            deb_cnt_q    <= deb_cnt_d;
            modo_q       <= bus.MODO_MONTO;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            digito_q     <= digito_d;
            digito_stb_q <= digito_stb_d;
            monto_q      <= monto_d;
            monto_stb_q  <= monto_stb_d;
            tipo_q       <= tipo_d;
            inval_q      <= inval_d;
        end
    end

    assign bus.FILAS          = filas_q;
    assign bus.DIGITO         = digito_q;
    assign bus.DIGITO_STB     = digito_stb_q;
    assign bus.MONTO          = monto_q;
    assign bus.MONTO_STB      = monto_stb_q;
    assign bus.TIPO_TRANS     = tipo_q;
    assign bus.TECLA_INVALIDA = inval_q;
endmodule

// File: tb/tb_teclado_atm.sv
// Keypad front-end bench: a keypad matrix model drives the columns, a reference model queues
// expected strobes, and a monitor checks each strobe the DUT presents against the queue.
module tb_teclado_atm;
    localparam int SC       = 2;
    localparam int DB       = 3;
    localparam int HOLD_MIN = 5 * SC + DB + 8;

    // Key codes: 0-9 digits, 10 A, 11 B, 12 C, 13 D, 14 '*', 15 '#'
    localparam int KA = 10, KB = 11, KC = 12, KD = 13, KSTAR = 14, KHASH = 15;

    typedef struct {
        logic [2:0]  stb;   // {MONTO_STB, DIGITO_STB, TECLA_INVALIDA}
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    teclado_atm_if bus();

    teclado_atm #(.SCAN_CYCLES(SC), .DEBOUNCE_CYCLES(DB)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    logic [15:0] key_mask = '0;
    logic [3:0]  cols;

    always_comb begin
        cols = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (key_mask[r*4+c] && !bus.FILAS[r]) cols[c] = 1'b0;
    end
    assign bus.COLUMNAS = cols;

    int          n_cmp = 0;
    int          n_fail = 0;
    exp_t        exp_q[$];
    longint      acc_m;
    int          cnt_m;
    logic        tipo_m, mode_m;
    logic [31:0] last_monto;
    logic [3:0]  last_dig;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int key_pos(input int code);
        case (code)
            1: return 0;   2: return 1;   3: return 2;   KA: return 3;
            4: return 4;   5: return 5;   6: return 6;   KB: return 7;
            7: return 8;   8: return 9;   9: return 10;  KC: return 11;
            KSTAR: return 12; 0: return 13; KHASH: return 14; default: return 15;
        endcase
    endfunction

    task automatic push_exp(input logic [2:0] s, input logic [31:0] v);
        exp_t e;
        e.stb = s;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        acc_m = 0; cnt_m = 0; tipo_m = 1'b0; last_monto = '0; last_dig = '0;
    endtask

    task automatic apply_model(input int code);
        if (code == KA) tipo_m = 1'b0;
        else if (code == KB) tipo_m = 1'b1;
        else if (!mode_m) begin
            if (code <= 9) begin
                push_exp(3'b010, 32'(code));
                last_dig = 4'(code);
            end else push_exp(3'b001, 32'd0);
        end else if (code <= 9) begin
            if (cnt_m < 9) begin
                acc_m = acc_m * 10 + code;
                cnt_m++;
            end else push_exp(3'b001, 32'd0);
        end else if (code == KSTAR) begin
            acc_m = 0; cnt_m = 0;
        end else if (code == KHASH && cnt_m > 0) begin
            push_exp(3'b100, 32'(acc_m));
            last_monto = 32'(acc_m);
            acc_m = 0; cnt_m = 0;
        end else push_exp(3'b001, 32'd0);
    endtask

    task automatic press(input int code, input int hold);
        apply_model(code);
        key_mask = 16'd1 << key_pos(code);
        repeat (hold) @(negedge clk);
        key_mask = '0;
        repeat (DB + 3 + $urandom_range(0, 3)) @(negedge clk);
        chk("tipo_trans", 32'(bus.TIPO_TRANS), 32'(tipo_m));
    endtask

    task automatic press_seq(input int codes[$]);
        foreach (codes[i]) press(codes[i], HOLD_MIN + $urandom_range(0, 6));
    endtask

    task automatic set_mode(input logic m);
        if (m != mode_m) begin
            acc_m = 0; cnt_m = 0;
        end
        mode_m = m;
        bus.MODO_MONTO = m;
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_filas"},  32'(bus.FILAS), 32'h0000000E);
        chk({tag, "_digito"}, 32'(bus.DIGITO), 32'd0);
        chk({tag, "_monto"},  bus.MONTO, 32'd0);
        chk({tag, "_tipo"},   32'(bus.TIPO_TRANS), 32'd0);
        chk({tag, "_strobes"}, 32'({bus.MONTO_STB, bus.DIGITO_STB, bus.TECLA_INVALIDA}), 32'd0);
    endtask

    // Monitor: every strobe must match the oldest queued expectation.
    exp_t       mon_e;
    logic [2:0] mon_stb;
    always @(negedge clk) begin
        if (!rst) begin
            mon_stb = {bus.MONTO_STB, bus.DIGITO_STB, bus.TECLA_INVALIDA};
            if (mon_stb != 3'b000) begin
                chk("strobe_single", 32'($countones(mon_stb)), 32'd1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 32'(mon_stb), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("strobe_kind", 32'(mon_stb), 32'(mon_e.stb));
                    if (mon_e.stb == 3'b010) chk("digito", 32'(bus.DIGITO), mon_e.val);
                    if (mon_e.stb == 3'b100) chk("monto", bus.MONTO, mon_e.val);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        bus.MODO_MONTO = 1'b0;
        mode_m = 1'b0;
        model_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("init");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // PIN entry
        press_seq('{6, 7, 6, 7});

        // Amount entry
        set_mode(1'b1);
        press_seq('{KB, 1, 5, 0, 0, 0, 0, KHASH});
        chk("monto_150000", bus.MONTO, 32'h000249F0);
        press_seq('{3, 5, 0, 0, 0, 0, KHASH});
        chk("monto_350000", bus.MONTO, 32'h00055730);

        // Reset in the middle of debouncing key 5
        set_mode(1'b0);
        key_mask = 16'd1 << key_pos(5);
        t = 0;
        while (bus.FILAS !== 4'b1101 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("row1_reached", 32'(t < 50), 32'd1);
        repeat (SC) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals("midreset");
        key_mask = '0;
        model_reset();
        rst = 1'b0;
        repeat (40) @(negedge clk);

        // Bounces shorter than the debounce window, then a long hold
        for (int i = 0; i < 8; i++) begin
            key_mask = 16'd1 << key_pos($urandom_range(0, 9));
            repeat ($urandom_range(1, DB - 1)) @(negedge clk);
            key_mask = '0;
            repeat (DB + 3 + $urandom_range(0, 4)) @(negedge clk);
        end
        press(8, 200);

        // Digit limit and empty confirm
        set_mode(1'b1);
        press_seq('{9, 9, 9, 9, 9, 9, 9, 9, 9, 9, KHASH});
        chk("monto_max", bus.MONTO, 32'd999999999);
        press_seq('{KHASH});

        // Clear, mode change, invalid keys
        press_seq('{1, 2, KSTAR, 7, KHASH});
        chk("monto_7", bus.MONTO, 32'd7);
        press_seq('{4});
        set_mode(1'b0);
        set_mode(1'b1);
        press_seq('{KHASH, KC, KD, KA});
        key_mask = (16'd1 << key_pos(1)) | (16'd1 << key_pos(2));
        repeat (40) @(negedge clk);
        key_mask = '0;
        repeat (DB + 4) @(negedge clk);

        // Random keys with occasional mode changes
        for (int i = 0; i < 70; i++) begin
            if ($urandom_range(0, 9) == 0) set_mode(~mode_m);
            press($urandom_range(0, 15), HOLD_MIN + $urandom_range(0, 6));
        end

        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("monto_hold", bus.MONTO, last_monto);
        chk("digito_hold", 32'(bus.DIGITO), 32'(last_dig));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
